// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared definitions for the BCD converter arbiter slice.
// Holds the sequencer state encoding, default widths and timing constants,
// and a helper that sizes requester index fields.
package bcd_conv_arbiter_pkg;

  typedef enum logic [2:0] {
    S_FLUSH = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam int unsigned DEF_BIN_W     = 16;
  localparam int unsigned DEF_BCD_W     = 20;
  localparam int unsigned DEF_TIMEOUT   = 255;
  localparam int unsigned DEF_FLUSH_CYC = 128;

  // Width of an index able to address n requesters (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_conv_arbiter_rr.sv
// rr_arbiter: purely combinational round-robin priority rotate.
// Ports:
//   req   - level requests, one bit per requester
//   ptr   - index of the previous winner; search starts at ptr+1
//   grant - one-hot winner, all zero when no request is set
//   valid - high when grant carries a winner
module rr_arbiter
  import bcd_conv_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PTR_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic             valid
);

  // Two ordered passes replace a modulo rotate: first the positions above
  // the pointer, then the wrap-around positions 0..ptr.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!valid && req[i] && (i > 32'(ptr))) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!valid && req[i] && (i <= 32'(ptr))) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: shares one binary-to-BCD converter between N_REQ
// requesters. Picks a requester round-robin, presents its operand, pulses
// the converter start, waits for done, captures the BCD word into that
// requester's result slice with a one-cycle ACK, then waits for the
// converter to fall back to its start state before the next grant.
// Ports:
//   CLK, RST        - clock (rising edge), synchronous active-high reset
//   REQ, BIN_IN     - level requests and flattened operands (slice i <-> REQ[i])
//   ACK, BCD_OUT    - per-requester update pulse and result registers
//   GRANT, BUSY     - one-hot converter owner, sequencer not idle
//   ERR             - sticky timeout flag
//   CONV_A, CONV_INIT, CONV_DONE, CONV_BCD - converter interface
module bcd_conv_arbiter
  import bcd_conv_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned BIN_W     = DEF_BIN_W,
  parameter int unsigned BCD_W     = DEF_BCD_W,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned FLUSH_CYC = DEF_FLUSH_CYC
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*BIN_W-1:0] BIN_IN,
  output logic [N_REQ-1:0]       ACK,
  output logic [N_REQ*BCD_W-1:0] BCD_OUT,
  output logic [N_REQ-1:0]       GRANT,
  output logic                   BUSY,
  output logic                   ERR,
  output logic [BIN_W-1:0]       CONV_A,
  output logic                   CONV_INIT,
  input  logic                   CONV_DONE,
  input  logic [BCD_W-1:0]       CONV_BCD
);

  localparam int unsigned PTR_W   = idx_width(N_REQ);
  localparam int unsigned CNT_MAX = (TIMEOUT > FLUSH_CYC) ? TIMEOUT : FLUSH_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(FLUSH_CYC - 1);

  state_t                   state;
  logic [PTR_W-1:0]         ptr;
  logic [CNT_W-1:0]         cnt;
  logic [N_REQ-1:0]         grant_q;
  logic [N_REQ-1:0]         ack_q;
  logic [N_REQ*BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]         conv_a_q;
  logic                     init_q;
  logic                     err_q;

  logic [N_REQ-1:0]         arb_grant;
  logic                     arb_valid;
  logic [PTR_W-1:0]         arb_idx;
  logic [BIN_W-1:0]         arb_operand;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (REQ),
    .ptr   (ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // Winner index and operand from the one-hot arbiter result.
  always_comb begin
    arb_idx     = '0;
    arb_operand = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        arb_idx     = PTR_W'(i);
        arb_operand = BIN_IN[i*BIN_W +: BIN_W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_FLUSH;
      ptr      <= PTR_W'(N_REQ - 1);
      cnt      <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      bcd_q    <= '0;
      conv_a_q <= '0;
      init_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ack_q  <= '0;
      init_q <= 1'b0;
      case (state)
        // The converter has no reset: leave it alone for FLUSH_CYC cycles,
        // then also wait until it is out of its done window.
        S_FLUSH: begin
          if (cnt != FL_LAST) begin
            cnt <= cnt + 1'b1;
          end else if (!CONV_DONE) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (arb_valid) begin
            grant_q  <= arb_grant;
            ptr      <= arb_idx;
            conv_a_q <= arb_operand;
            init_q   <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (CONV_DONE) begin
            ack_q <= grant_q;
            for (int unsigned i = 0; i < N_REQ; i++) begin
              if (grant_q[i]) begin
                bcd_q[i*BCD_W +: BCD_W] <= CONV_BCD;
              end
            end
            cnt   <= '0;
            state <= S_DRAIN;
          end else if (cnt == TO_LAST) begin
            err_q <= 1'b1;
            cnt   <= '0;
            state <= S_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (!CONV_DONE) begin
            grant_q <= '0;
            state   <= S_IDLE;
          end else if (cnt == TO_LAST) begin
            err_q   <= 1'b1;
            grant_q <= '0;
            cnt     <= '0;
            state   <= S_FLUSH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_FLUSH;
        end
      endcase
    end
  end

  assign ACK       = ack_q;
  assign BCD_OUT   = bcd_q;
  assign GRANT     = grant_q;
  assign BUSY      = (state != S_IDLE);
  assign ERR       = err_q;
  assign CONV_A    = conv_a_q;
  assign CONV_INIT = init_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: behavioural converter model,
// per-requester expected-result queues and a round-robin reference model.
module tb_bcd_conv_arbiter;

  localparam int N  = 3;
  localparam int BW = 16;
  localparam int CW = 20;
  localparam int TO = 255;
  localparam int FC = 128;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [N-1:0]    REQ = '0;
  logic [N*BW-1:0] BIN_IN = '0;
  logic [N-1:0]    ACK;
  logic [N*CW-1:0] BCD_OUT;
  logic [N-1:0]    GRANT;
  logic            BUSY;
  logic            ERR;
  logic [BW-1:0]   CONV_A;
  logic            CONV_INIT;
  logic            CONV_DONE = 1'b0;
  logic [CW-1:0]   CONV_BCD = '0;

  bcd_conv_arbiter #(
    .N_REQ     (N),
    .BIN_W     (BW),
    .BCD_W     (CW),
    .TIMEOUT   (TO),
    .FLUSH_CYC (FC)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .BIN_IN    (BIN_IN),
    .ACK       (ACK),
    .BCD_OUT   (BCD_OUT),
    .GRANT     (GRANT),
    .BUSY      (BUSY),
    .ERR       (ERR),
    .CONV_A    (CONV_A),
    .CONV_INIT (CONV_INIT),
    .CONV_DONE (CONV_DONE),
    .CONV_BCD  (CONV_BCD)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [CW-1:0] exp_q [N][$];
  logic [N-1:0]  ack_seen = '0;
  int            grant_log[$];

  function automatic logic [CW-1:0] to_bcd(input int unsigned v);
    logic [CW-1:0] r;
    int unsigned   x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [CW-1:0] slice(input int i);
    return BCD_OUT[i*CW +: CW];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Behavioural converter: start state until INIT, a short latency, DONE
  // high for 31 cycles with the BCD word, then back to start by itself.
  // conv_mode 1 = never finishes, 2 = DONE never falls.
  int            conv_mode = 0;
  int            init_cnt = 0;
  logic          conv_busy = 1'b0;
  int            lat = 0;
  int            hold = 0;
  logic [BW-1:0] latched = '0;

  initial begin
    logic          init_s;
    logic [BW-1:0] a_s;
    forever begin
      @(negedge CLK);
      init_s = CONV_INIT;
      a_s    = CONV_A;
      @(posedge CLK);
      #1;
      if (conv_busy) begin
        if (lat > 0) lat--;
        else if (!CONV_DONE) begin
          CONV_DONE = 1'b1;
          CONV_BCD  = to_bcd(latched);
          hold      = 31;
        end else if (conv_mode != 2) begin
          if (hold > 1) hold--;
          else begin
            CONV_DONE = 1'b0;
            CONV_BCD  = CW'($urandom);
            conv_busy = 1'b0;
          end
        end
      end
      if (init_s) begin
        init_cnt++;
        check("init_in_start_state", {31'd0, conv_busy | CONV_DONE}, 32'd0);
        if (!conv_busy && conv_mode != 1) begin
          conv_busy = 1'b1;
          lat       = $urandom_range(4, 12);
          latched   = a_s;
        end
      end
    end
  end

  // Monitor: round-robin reference for grants, queue pop on every ACK.
  initial begin
    logic [N-1:0]    req_prev = '0;
    logic [N-1:0]    grant_prev = '0;
    logic [N*BW-1:0] bin_prev = '0;
    logic            rst_prev = 1'b1;
    int              model_ptr = N - 1;
    logic [CW-1:0]   shadow [N];
    for (int i = 0; i < N; i++) shadow[i] = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        model_ptr = N - 1;
        for (int i = 0; i < N; i++) shadow[i] = '0;
        rst_prev = 1'b1;
      end else begin
        if (!rst_prev && grant_prev == '0 && GRANT != '0) begin
          int j;
          logic [N-1:0] oh;
          j = rr_pick(req_prev, model_ptr);
          oh = (j < 0) ? '0 : N'(1 << j);
          check("grant_onehot_rr", 32'(GRANT), 32'(oh));
          if (j >= 0) begin
            check("conv_a_operand", 32'(CONV_A), 32'(bin_prev[j*BW +: BW]));
            model_ptr = j;
          end
          check("init_with_grant", 32'(CONV_INIT), 32'd1);
          grant_log.push_back(j);
        end
        for (int i = 0; i < N; i++) begin
          if (ACK[i]) begin
            ack_seen[i] = 1'b1;
            check("ack_owner", 32'(GRANT[i]), 32'd1);
            if (exp_q[i].size() == 0) begin
              check("ack_unexpected", 32'(i) + 32'h100, 32'hFFFF);
              shadow[i] = slice(i);
            end else begin
              shadow[i] = exp_q[i].pop_front();
            end
            for (int k = 0; k < N; k++) check("bcd_slice", 32'(slice(k)), 32'(shadow[k]));
          end
        end
        rst_prev = 1'b0;
      end
      req_prev   = REQ;
      grant_prev = GRANT;
      bin_prev   = BIN_IN;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic request(input int i, input logic [BW-1:0] v);
    BIN_IN[i*BW +: BW] = v;
    REQ[i]             = 1'b1;
    ack_seen[i]        = 1'b0;
    exp_q[i].push_back(to_bcd(32'(v)));
  endtask

  task automatic wait_ack(input int i, input int budget, input string name);
    for (int c = 0; c < budget && !ack_seen[i]; c++) tick();
    check(name, 32'(ack_seen[i]), 32'd1);
  endtask

  task automatic wait_grant(input int i, input int budget, input string name);
    for (int c = 0; c < budget && !GRANT[i]; c++) tick();
    check(name, 32'(GRANT[i]), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int c = 0; c < budget && BUSY; c++) tick();
    check(name, 32'(BUSY), 32'd0);
  endtask

  task automatic do_reset();
    tick();
    RST = 1'b1;
    REQ = '0;
    for (int i = 0; i < N; i++) exp_q[i].delete();
    ack_seen = '0;
    tick();
    RST = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ack"}, 32'(ACK), 32'd0);
    check({tag, "_grant"}, 32'(GRANT), 32'd0);
    check({tag, "_conv_a"}, 32'(CONV_A), 32'd0);
    check({tag, "_init"}, 32'(CONV_INIT), 32'd0);
    check({tag, "_err"}, 32'(ERR), 32'd0);
    check({tag, "_busy"}, 32'(BUSY), 32'd1);
    for (int i = 0; i < N; i++) check({tag, "_bcd"}, 32'(slice(i)), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    int            g;
    int            i0;
    logic [BW-1:0] op;
    logic [BW-1:0] ops [N];
    logic          all_empty;

    // Reset values
    tick();
    tick();
    RST = 1'b0;
    check_zero_outputs("reset");
    wait_idle(FC + 20, "flush_exit");

    // Single request
    i0 = init_cnt;
    request(1, 16'd255);
    wait_ack(1, 100, "t1_ack");
    REQ[1] = 1'b0;
    check("t1_slice1", 32'(slice(1)), 32'h00255);
    check("t1_slice0", 32'(slice(0)), 32'd0);
    check("t1_slice2", 32'(slice(2)), 32'd0);
    check("t1_one_init", 32'(init_cnt - i0), 32'd1);
    wait_idle(60, "t1_idle");

    // All three requesting from reset pointer
    do_reset();
    wait_idle(FC + 60, "t2_flush");
    grant_log.delete();
    request(0, 16'd7);
    request(1, 16'd65535);
    request(2, 16'd1000);
    for (int c = 0; c < 400 && ack_seen != 3'b111; c++) begin
      tick();
      for (int i = 0; i < N; i++) if (ack_seen[i]) REQ[i] = 1'b0;
    end
    check("t2_all_acked", 32'(ack_seen), 32'h7);
    REQ = '0;
    check("t2_grant_count", 32'(grant_log.size()), 32'd3);
    for (int k = 0; k < 3 && k < grant_log.size(); k++)
      check("t2_grant_order", 32'(grant_log[k]), 32'(k));
    check("t2_slice0", 32'(slice(0)), 32'h00007);
    check("t2_slice1", 32'(slice(1)), 32'h65535);
    check("t2_slice2", 32'(slice(2)), 32'h01000);
    wait_idle(60, "t2_idle");

    // Requester drops REQ right after its grant
    op = BW'($urandom);
    request(2, op);
    wait_grant(2, 20, "t3_grant2");
    tick();
    REQ[2] = 1'b0;
    wait_ack(2, 100, "t3_ack2");
    check("t3_slice2", 32'(slice(2)), 32'(to_bcd(32'(op))));
    wait_idle(60, "t3_idle");
    grant_log.delete();
    request(0, BW'($urandom));
    wait_ack(0, 100, "t3_ack0");
    REQ[0] = 1'b0;
    check("t3_next_grant0", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF, 32'd0);
    wait_idle(60, "t3_idle2");

    // Converter never signals done: RUN timeout
    conv_mode = 1;
    request(0, 16'd123);
    exp_q[0].delete();
    wait_grant(0, 20, "t4_grant");
    g = cyc;
    REQ[0] = 1'b0;
    for (int c = 0; c < 400 && !ERR; c++) tick();
    check("t4_err_set", 32'(ERR), 32'd1);
    check("t4_run_cycles", 32'(cyc - g), 32'(TO + 1));
    wait_idle(5, "t4_back_idle");
    repeat (20) tick();
    check("t4_err_sticky", 32'(ERR), 32'd1);
    conv_mode = 0;
    do_reset();
    check("t4_err_clear", 32'(ERR), 32'd0);
    wait_idle(FC + 60, "t4_flush");

    // Reset in the middle of RUN; REQ[1] stays held throughout
    request(1, 16'd4321);
    wait_grant(1, 20, "t5_grant");
    tick();
    tick();
    RST = 1'b1;
    for (int i = 0; i < N; i++) exp_q[i].delete();
    tick();
    RST = 1'b0;
    check_zero_outputs("t5_rst");
    exp_q[1].push_back(to_bcd(32'd4321));
    n = 0;
    while (BUSY && n < 400) begin
      n++;
      tick();
    end
    check("t5_flush_len", 32'(n >= FC), 32'd1);
    wait_ack(1, 100, "t5_ack");
    REQ[1] = 1'b0;
    wait_idle(60, "t5_idle");

    // Converter done stuck high: DRAIN timeout, then FLUSH holds off INIT
    conv_mode = 2;
    request(2, 16'd9999);
    wait_ack(2, 100, "t6_ack");
    REQ[2] = 1'b0;
    for (int c = 0; c < 400 && !ERR; c++) tick();
    check("t6_err_set", 32'(ERR), 32'd1);
    i0 = init_cnt;
    request(0, 16'd42);
    repeat (300) tick();
    check("t6_busy_flush", 32'(BUSY), 32'd1);
    check("t6_no_grant", 32'(GRANT), 32'd0);
    check("t6_no_init", 32'(init_cnt - i0), 32'd0);
    conv_mode = 0;
    wait_ack(0, 300, "t6_ack0_after_release");
    REQ[0] = 1'b0;
    check("t6_err_sticky", 32'(ERR), 32'd1);

    // Random traffic
    do_reset();
    wait_idle(FC + 60, "t7_flush");
    for (int i = 0; i < N; i++) ops[i] = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (ack_seen[i]) begin
          ack_seen[i] = 1'b0;
          if ($urandom_range(0, 3) == 0) exp_q[i].push_back(to_bcd(32'(ops[i])));
          else REQ[i] = 1'b0;
        end else if (!REQ[i] && $urandom_range(0, 15) == 0) begin
          case ($urandom_range(0, 5))
            0: op = 16'd0;
            1: op = 16'd65535;
            2: op = 16'd9999;
            3: op = 16'd10000;
            default: op = BW'($urandom);
          endcase
          ops[i] = op;
          request(i, op);
        end
      end
    end
    all_empty = 1'b0;
    for (int c = 0; c < 3000 && !all_empty; c++) begin
      tick();
      for (int i = 0; i < N; i++) if (ack_seen[i]) begin
        ack_seen[i] = 1'b0;
        REQ[i] = 1'b0;
      end
      all_empty = (REQ == '0);
      for (int i = 0; i < N; i++) if (exp_q[i].size() != 0) all_empty = 1'b0;
    end
    check("t7_all_served", 32'(all_empty), 32'd1);
    wait_idle(60, "t7_idle");
    check("t7_no_err", 32'(ERR), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares the single binary-to-BCD converter in the calculator between N_REQ requesters, e.g. operand A, operand B and the ALU result display path.
- Arbitrates round-robin and sequences the converter: presents the operand, pulses its INIT, waits for DONE, captures the BCD word, then waits for the converter to return to its start state.
- Delivers each result to a per-requester register with a one-cycle ACK.
- Sits between the calculator datapath and the converter/control pair.

Parameters:
- N_REQ, 3, number of requesters.
- BIN_W, 16, binary operand width.
- BCD_W, 20, BCD result width (5 digits).
- TIMEOUT, 255, max cycles allowed in RUN or DRAIN before abort.
- FLUSH_CYC, 128, cycles the converter is left untouched after reset.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  N_REQ  level request; requester holds it until ACK.
- BIN_IN  in  N_REQ*BIN_W  flattened operands; slice i belongs to REQ[i].
- ACK  out  N_REQ  one-cycle pulse when result slice i is updated.
- BCD_OUT  out  N_REQ*BCD_W  per-requester result registers.
- GRANT  out  N_REQ  one-hot owner of the converter, 0 when idle.
- BUSY  out  1  high in any state other than IDLE.
- ERR  out  1  sticky timeout flag; cleared only by RST.
- CONV_A  out  BIN_W  operand to converter.
- CONV_INIT  out  1  converter start pulse.
- CONV_DONE  in  1  converter done; stays high ~31 cycles, then the converter self-returns to start.
- CONV_BCD  in  BCD_W  converter result.

Behaviour:
- Reset values: ACK=0, BCD_OUT=0, GRANT=0, CONV_A=0, CONV_INIT=0, ERR=0, round-robin pointer=N_REQ-1, state=FLUSH. BUSY follows the state and is therefore 1 in FLUSH.
- All outputs are registered. CONV_A is held constant from LOAD through the exit from DRAIN.
- FLUSH:
  - Counts FLUSH_CYC cycles with CONV_INIT=0.
  - Then waits for CONV_DONE=0, then goes to IDLE.
  - This covers reset arriving while the converter (which has no reset) is mid-conversion.
- IDLE:
  - If any REQ is set, pick the first set bit searching from pointer+1 upward, wrapping modulo N_REQ.
  - Next cycle: GRANT one-hot, CONV_A=BIN_IN slice, pointer=winner, state=LOAD.
- LOAD (exactly 1 cycle): CONV_INIT=1, then RUN. The timeout counter clears on entering RUN.
- RUN:
  - Waits for CONV_DONE=1.
  - The cycle after DONE is seen high, register CONV_BCD into BCD_OUT slice[winner] and pulse ACK[winner] in that same cycle, then go to DRAIN.
  - If the counter reaches TIMEOUT first: set ERR, no ACK, no capture, go to DRAIN.
- DRAIN:
  - Waits for CONV_DONE=0, then returns to IDLE with GRANT=0.
  - The counter clears on entry; on TIMEOUT set ERR and go to FLUSH.
  - DRAIN guarantees the next INIT lands while the converter is in its start state.
- Latency: REQ sampled in IDLE at cycle t gives GRANT at t+1, CONV_INIT at t+1, and ACK one cycle after the first CONV_DONE=1.
- Minimum spacing between two grants is one converter DONE window plus 2 cycles.
- REQ deasserted after grant: the conversion completes, and the result and ACK are still delivered.
- REQ deasserted before grant: the request is ignored.
- A requester still holding REQ in the cycle of its ACK is not re-granted unless it is the only requester. Round robin moves the pointer past it.
- Simultaneous requests: exactly one GRANT bit is set. Over N_REQ consecutive grants, no requester is skipped while its REQ stays high.
- CONV_DONE already high in IDLE or LOAD is ignored; only RUN samples it.
- RST in any state: immediate return to reset values and FLUSH. Any pending ACK is lost.

Decomposition:
- Shared package holds:
  - state encodings: S_FLUSH, S_IDLE, S_LOAD, S_RUN, S_DRAIN (3 bits);
  - default widths: BIN_W, BCD_W;
  - default TIMEOUT and FLUSH_CYC.
- One sub-module: rr_arbiter (N_REQ requests + pointer in, one-hot grant + valid out, purely combinational priority rotate). Keep FSM, counters and result registers in the top module.

Test Plan:
- Single request, REQ[1]=1, BIN_IN slice1=16'd255, behavioural converter model -> GRANT=3'b010, one CONV_INIT pulse, then ACK[1] pulse and BCD_OUT slice1=20'h00255; other slices stay 0.
- All REQ=3'b111 held, operands 16'd7/16'd65535/16'd1000 -> grants in order 0,1,2. Slices become 20'h00007, 20'h65535 and 20'h01000. No second INIT is issued while CONV_DONE=1.
- REQ[2] pulses low right after grant -> ACK[2] still asserted and slice2 updated. A later REQ[0]-only request is served next.
- CONV_DONE stuck at 0 after INIT -> after 255 cycles in RUN: ERR=1, no ACK, return to IDLE, ERR stays 1 until RST.
- RST asserted mid-RUN -> all outputs 0 the next cycle, BUSY=1 for ≥128 cycles. No CONV_INIT until FLUSH completes and CONV_DONE=0. The next request is then served normally.
- CONV_DONE stuck at 1 -> DRAIN timeout sets ERR, enters FLUSH, and no INIT is issued while DONE stays high.
